// File: rtl/can_bit_destuffer_if.sv
// rtl/can_bit_destuffer_if.sv - bus-side signal bundle of the CAN bit destuffer
// master: upstream/decoder side, drives sync unit and frame decoder controls, observes bit stream
// slave : destuffer side, consumes sample strobes and controls, produces destuffed bit stream
interface can_bit_destuffer_if;
    logic syncIn;
    logic oneShotSample;
    logic syncCANClk;
    logic multiSelect;
    logic destuffEn;
    logic frameEnd;
    logic bitValid;
    logic bitOut;
    logic sofDetect;
    logic stuffDrop;
    logic stuffError;
    logic busIdle;

    modport master (
        output syncIn, oneShotSample, syncCANClk, multiSelect, destuffEn, frameEnd,
        input  bitValid, bitOut, sofDetect, stuffDrop, stuffError, busIdle
    );

    modport slave (
        input  syncIn, oneShotSample, syncCANClk, multiSelect, destuffEn, frameEnd,
        output bitValid, bitOut, sofDetect, stuffDrop, stuffError, busIdle
    );
endinterface

// File: rtl/can_bit_destuffer.sv
// rtl/can_bit_destuffer.sv - CAN bit former, idle/SOF detector and bit destuffer
// clk    : system clock
// resetN : synchronous active-low reset
// bus    : slave side of can_bit_destuffer_if
//          in : syncIn, oneShotSample, syncCANClk, multiSelect, destuffEn, frameEnd
//          out: bitValid, bitOut, sofDetect, stuffDrop, stuffError (strobes), busIdle (level)
module can_bit_destuffer #(
    parameter int IDLE_BITS = 11,
    parameter int STUFF_LEN = 5
) (
    input  logic                 clk,
    input  logic                 resetN,
    can_bit_destuffer_if.slave   bus
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, FRAME, ERROR} state_t;

    localparam logic [3:0] IDLE_CNT  = 4'(IDLE_BITS);
    localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

    state_t     state_q, state_d;
    logic [1:0] smp_q, smp_d;
    logic [1:0] cnt_q, cnt_d;
    logic       multi_q, multi_d;
    logic       clk_prev_q;
    logic [3:0] rec_q, rec_d;
    logic [2:0] run_q, run_d;
    logic       last_q, last_d;
    logic       valid_q, valid_d;
    logic       out_q, out_d;
    logic       sof_q, sof_d;
    logic       drop_q, drop_d;
    logic       err_q, err_d;
    logic       idle_q, idle_d;

    logic       fall;
    logic       multi_eff;
    logic       done;
    logic       bit_v;
    logic       fe_hit;
    logic [3:0] rec_base;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= WAIT_IDLE;
            smp_q      <= '0;
            cnt_q      <= '0;
            multi_q    <= 1'b0;
            clk_prev_q <= 1'b0;
            rec_q      <= '0;
            run_q      <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= 1'b1;
            sof_q      <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            cnt_q      <= cnt_d;
            multi_q    <= multi_d;
            clk_prev_q <= bus.syncCANClk;
            rec_q      <= rec_d;
            run_q      <= run_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            sof_q      <= sof_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
        end
    end

    always_comb begin
        smp_d     = smp_q;
        cnt_d     = cnt_q;
        multi_d   = multi_q;
        done      = 1'b0;
        fall      = clk_prev_q & ~bus.syncCANClk;
        // the mode for a bit is taken at its first sample
        multi_eff = (cnt_q == 2'd0) ? bus.multiSelect : multi_q;
        // third sample is used straight from the input, so only two are stored
        bit_v     = multi_eff ? ((smp_q[0] & smp_q[1]) | (smp_q[0] & bus.syncIn) | (smp_q[1] & bus.syncIn))
                              : bus.syncIn;

        // end of sampling window clears any partial bit, taking priority over a strobe
        if (fall) begin
            cnt_d = 2'd0;
        end else if (bus.oneShotSample) begin
            multi_d = multi_eff;
            if (cnt_q == 2'd0) smp_d[0] = bus.syncIn;
            else               smp_d[1] = bus.syncIn;
            if (!multi_eff || cnt_q == 2'd2) begin
                done  = 1'b1;
                cnt_d = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        last_d  = last_q;
        valid_d = 1'b0;
        out_d   = out_q;
        sof_d   = 1'b0;
        drop_d  = 1'b0;
        err_d   = 1'b0;

        // frameEnd overrides a coincident bit, which is then counted as in WAIT_IDLE
        fe_hit   = bus.frameEnd && (state_q == FRAME || state_q == ERROR);
        rec_base = fe_hit ? 4'd0 : rec_q;
        rec_d    = rec_base;
        if (done) begin
            if (!bit_v)                   rec_d = 4'd0;
            else if (rec_base != IDLE_CNT) rec_d = rec_base + 4'd1;
        end

        if (fe_hit) begin
            state_d = WAIT_IDLE;
        end else if (done) begin
            case (state_q)
                IDLE: begin
                    if (!bit_v) begin
                        valid_d = 1'b1;
                        out_d   = 1'b0;
                        sof_d   = 1'b1;
                        run_d   = 3'd1;
                        last_d  = 1'b0;
                        state_d = FRAME;
                    end
                end
                FRAME: begin
                    if (bus.destuffEn && run_q == STUFF_CNT) begin
                        if (bit_v != last_q) begin
                            drop_d = 1'b1;
                            run_d  = 3'd1;
                            last_d = bit_v;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ERROR;
                        end
                    end else begin
                        valid_d = 1'b1;
                        out_d   = bit_v;
                        last_d  = bit_v;
                        if (!bus.destuffEn)     run_d = 3'd0;
                        else if (bit_v == last_q) run_d = run_q + 3'd1;
                        else                    run_d = 3'd1;
                    end
                end
                default: ;
            endcase
        end

        if ((state_d == WAIT_IDLE || state_d == ERROR) && rec_d == IDLE_CNT) state_d = IDLE;

        idle_d = (state_d == IDLE);
    end

    assign bus.bitValid   = valid_q;
    assign bus.bitOut     = out_q;
    assign bus.sofDetect  = sof_q;
    assign bus.stuffDrop  = drop_q;
    assign bus.stuffError = err_q;
    assign bus.busIdle    = idle_q;
endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb/tb_can_bit_destuffer.sv - self-checking bench for can_bit_destuffer
module tb_can_bit_destuffer;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    can_bit_destuffer_if bus();
    can_bit_destuffer #(.IDLE_BITS(11), .STUFF_LEN(5)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    localparam int M_WAIT = 0, M_IDLE = 1, M_FRAME = 2, M_ERR = 3;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;

    int m_st = M_WAIT, m_rec = 0, m_run = 0;
    bit m_last = 0, m_prev = 0, m_multi = 0;
    bit smpq[$];

    bit exp_valid = 0, exp_out = 1, exp_sof = 0, exp_drop = 0, exp_err = 0, exp_idle = 0;
    bit nx_valid, nx_out, nx_sof, nx_drop, nx_err, nx_idle;
    bit cap_valid, cap_out, cap_sof, cap_drop, cap_err, cap_idle;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%b want=%b at %0t", nm, act, expv, $time);
        end
    endtask

    // Behavioural reference: bits are formed from a list of samples, and the
    // frame rules are applied to plain counters.
    task automatic model_eval();
        bit fall, done, b;
        int ones;
        nx_valid = 0; nx_sof = 0; nx_drop = 0; nx_err = 0; nx_out = exp_out;
        if (!resetN) begin
            m_st = M_WAIT; m_rec = 0; m_run = 0; m_last = 0; m_prev = 0; m_multi = 0;
            smpq.delete();
            nx_out = 1; nx_idle = 0;
            return;
        end
        fall = m_prev && !bus.syncCANClk;
        m_prev = bus.syncCANClk;
        done = 0; b = 1;
        if (fall) smpq.delete();
        else if (bus.oneShotSample) begin
            if (smpq.size() == 0) m_multi = bus.multiSelect;
            smpq.push_back(bus.syncIn);
            if (smpq.size() == (m_multi ? 3 : 1)) begin
                done = 1;
                ones = 0;
                foreach (smpq[i]) ones += int'(smpq[i]);
                b = (ones * 2 > smpq.size());
                smpq.delete();
            end
        end
        if (bus.frameEnd && (m_st == M_FRAME || m_st == M_ERR)) begin
            m_st = M_WAIT;
            m_rec = 0;
        end else if (done && m_st == M_IDLE && !b) begin
            nx_valid = 1; nx_out = 0; nx_sof = 1; m_run = 1; m_last = 0; m_st = M_FRAME;
        end else if (done && m_st == M_FRAME) begin
            if (bus.destuffEn && m_run == 5) begin
                if (b != m_last) begin nx_drop = 1; m_run = 1; m_last = b; end
                else begin nx_err = 1; m_st = M_ERR; end
            end else begin
                nx_valid = 1; nx_out = b;
                m_run = !bus.destuffEn ? 0 : (b == m_last) ? m_run + 1 : 1;
                m_last = b;
            end
        end
        if (done) m_rec = b ? ((m_rec < 11) ? m_rec + 1 : 11) : 0;
        if ((m_st == M_WAIT || m_st == M_ERR) && m_rec == 11) m_st = M_IDLE;
        nx_idle = (m_st == M_IDLE);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        exp_valid = nx_valid; exp_out = nx_out; exp_sof = nx_sof;
        exp_drop = nx_drop; exp_err = nx_err; exp_idle = nx_idle;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("outputs",
                {bus.bitValid, bus.sofDetect, bus.stuffDrop, bus.stuffError, bus.busIdle, exp_valid ? bus.bitOut : 1'b0},
                {exp_valid, exp_sof, exp_drop, exp_err, exp_idle, exp_valid ? exp_out : 1'b0});
            if (bus.bitValid) vcnt++;
        end
    end

    // s[0] is the first sample sent
    task automatic send_bit(input bit m, input bit [2:0] s, input bit fe = 0);
        int n;
        n = m ? 3 : 1;
        bus.syncCANClk = 1; bus.multiSelect = m;
        step();
        for (int i = 0; i < n; i++) begin
            bus.oneShotSample = 1; bus.syncIn = s[i]; bus.frameEnd = fe && (i == n - 1);
            step();
            cap_valid = bus.bitValid; cap_out = bus.bitOut; cap_sof = bus.sofDetect;
            cap_drop = bus.stuffDrop; cap_err = bus.stuffError; cap_idle = bus.busIdle;
            bus.oneShotSample = 0; bus.frameEnd = 0;
            step();
        end
        bus.syncCANClk = 0;
        step();
    endtask

    task automatic send1(input bit b);
        send_bit(0, {3{b}});
    endtask

    // two dominant strobes of a multi-sample bit, then the window closes;
    // with coinc=1 the second strobe lands on the closing edge itself
    task automatic partial(input bit coinc);
        bus.syncCANClk = 1; bus.multiSelect = 1;
        step();
        bus.oneShotSample = 1; bus.syncIn = 0; step();
        bus.oneShotSample = 0; step();
        bus.oneShotSample = 1; bus.syncIn = 0;
        if (coinc) bus.syncCANClk = 0;
        step();
        bus.oneShotSample = 0; bus.syncCANClk = 0; step();
        step();
    endtask

    initial begin
        int v0;
        bit lastb;
        bit [2:0] s;
        int r;
        bit m;
        bus.syncIn = 1; bus.oneShotSample = 0; bus.syncCANClk = 0;
        bus.multiSelect = 0; bus.destuffEn = 1; bus.frameEnd = 0;
        resetN = 0;
        step(); step();
        cmp_en = 1;
        chk("reset_values", {bus.bitValid, bus.bitOut, bus.sofDetect, bus.stuffDrop, bus.stuffError, bus.busIdle}, 6'b010000);
        resetN = 1;

        repeat (10) send1(1);
        chk("idle_after_10", {5'b0, bus.busIdle}, 6'b0);
        send1(1);
        chk("idle_after_11", {5'b0, cap_idle}, 6'b1);
        send1(0);
        chk("sof", {2'b0, cap_valid, cap_out, cap_sof, cap_idle}, 6'b001010);

        repeat (4) send1(0);
        send1(1);
        chk("stuff_drop", {3'b0, cap_valid, cap_drop, cap_err}, 6'b000010);
        send1(1);
        chk("after_stuff", {4'b0, cap_valid, cap_out}, 6'b000011);
        repeat (3) send1(1);
        send1(0);
        chk("run_two_pin", {4'b0, cap_valid, cap_drop}, 6'b000001);

        send_bit(0, 3'b111, 1);
        chk("frameend_bit", {4'b0, cap_valid, cap_idle}, 6'b0);
        repeat (9) send1(1);
        chk("frameend_rec10", {5'b0, bus.busIdle}, 6'b0);
        send1(1);
        chk("frameend_rec11", {5'b0, cap_idle}, 6'b1);

        send1(0);
        repeat (4) send1(0);
        send1(0);
        chk("stuff_error", {4'b0, cap_valid, cap_err}, 6'b000001);
        v0 = vcnt;
        send1(0); send1(1); send1(1); send1(0);
        repeat (10) send1(1);
        chk("error_silent", 6'(vcnt - v0), 6'd0);
        chk("error_rec10", {5'b0, bus.busIdle}, 6'b0);
        send1(1);
        chk("error_rec11", {5'b0, cap_idle}, 6'b1);

        bus.destuffEn = 0;
        send_bit(1, 3'b000);
        chk("multi_sof", {4'b0, cap_sof, cap_out}, 6'b000010);
        v0 = vcnt;
        send_bit(1, 3'b010);
        chk("maj_010", {4'b0, cap_valid, cap_out}, 6'b000010);
        send_bit(1, 3'b011);
        chk("maj_110", {4'b0, cap_valid, cap_out}, 6'b000011);
        chk("one_valid_per_bit", 6'(vcnt - v0), 6'd2);

        v0 = vcnt;
        partial(0);
        send_bit(1, 3'b111);
        chk("partial_discard", {4'b0, cap_valid, cap_out}, 6'b000011);
        partial(1);
        send_bit(1, 3'b111);
        chk("coincident_clear", {4'b0, cap_valid, cap_out}, 6'b000011);
        chk("partial_count", 6'(vcnt - v0), 6'd2);

        send1(0);
        resetN = 0;
        step();
        chk("mid_reset", {bus.bitValid, bus.bitOut, bus.sofDetect, bus.stuffDrop, bus.stuffError, bus.busIdle}, 6'b010000);
        resetN = 1;
        v0 = vcnt;
        repeat (10) send1(1);
        send1(0);
        chk("post_reset_silent", 6'(vcnt - v0), 6'd0);

        lastb = 1;
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                resetN = 0; step(); resetN = 1;
            end else if (r < 3) begin
                partial($urandom_range(0, 1) == 1);
            end else if (r < 5) begin
                bus.frameEnd = 1; step(); bus.frameEnd = 0;
            end else if (r < 9) begin
                repeat (12) send1(1);
                lastb = 1;
            end else begin
                if ($urandom_range(0, 19) == 0) bus.destuffEn = ~bus.destuffEn;
                if ($urandom_range(0, 9) >= 7) lastb = ~lastb;
                m = ($urandom_range(0, 1) == 1);
                s = {3{lastb}};
                if (m && $urandom_range(0, 1) == 1) begin
                    int k;
                    k = $urandom_range(0, 2);
                    s[k] = ~s[k];
                end
                send_bit(m, s, $urandom_range(0, 29) == 0);
            end
        end
        step(); step();
        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
